// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports, the dmem pins and status for dmem_arbiter.
// Handshake: reqN stays high with a stable command until ackN pulses for one cycle; ackN completes it.
interface dmem_arbiter_if #(parameter int n = 32);
  logic         req0;
  logic         req1;
  logic         we0;
  logic         we1;
  logic [n-1:0] addr0;
  logic [n-1:0] addr1;
  logic [n-1:0] wdata0;
  logic [n-1:0] wdata1;
  logic         ack0;
  logic         ack1;
  logic [n-1:0] rdata0;
  logic [n-1:0] rdata1;
  logic         mem_we;
  logic [n-1:0] mem_addr;
  logic [n-1:0] mem_wdata;
  logic [n-1:0] mem_rdata;
  logic         busy;
  logic         owner;
  logic [1:0]   state_dbg;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, mem_we, mem_addr, mem_wdata, busy, owner, state_dbg
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, mem_we, mem_addr, mem_wdata, busy, owner, state_dbg
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port dmem between the CPU (port 0) and loader (port 1).
// Each transaction is IDLE (latch) -> ACCESS (drive dmem) -> DONE (ack), three cycles total.
module dmem_arbiter #(
  parameter int n = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t       r_state;
  logic         r_last;
  logic         r_owner;
  logic         r_we_q;
  logic         r_busy;
  logic         r_ack0;
  logic         r_ack1;
  logic [n-1:0] r_mem_addr;
  logic [n-1:0] r_mem_wdata;
  logic [n-1:0] r_rdata0;
  logic [n-1:0] r_rdata1;

  logic         w_any_req;
  logic         w_grant;

  // On a tie the port that was not served last wins; otherwise the lone requester.
  always_comb begin
    w_any_req = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      w_grant = ~r_last;
    end else begin
      w_grant = bus.req1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_we_q      <= 1'b0;
      r_busy      <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner     <= w_grant;
            r_we_q      <= w_grant ? bus.we1    : bus.we0;
            r_mem_addr  <= w_grant ? bus.addr1  : bus.addr0;
            r_mem_wdata <= w_grant ? bus.wdata1 : bus.wdata0;
            r_busy      <= 1'b1;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!r_we_q) begin
            if (r_owner) begin
              r_rdata1 <= bus.mem_rdata;
            end else begin
              r_rdata0 <= bus.mem_rdata;
            end
          end
          r_ack0  <= ~r_owner;
          r_ack1  <= r_owner;
          r_state <= DONE;
        end
        DONE: begin
          r_last  <= r_owner;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Gating with rst_n lets a reset that lands during ACCESS abort the write before the edge.
  assign bus.mem_we    = r_we_q & rst_n & (r_state == ACCESS);
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.ack0      = r_ack0;
  assign bus.ack1      = r_ack1;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.busy      = r_busy;
  assign bus.owner     = r_owner;
  assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, directed corner sequences and a random run
// checked against a transaction-level model with its own copy of memory.
module tb_dmem_arbiter;
  localparam int N = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.n(N)) bus ();
  dmem_arbiter #(.n(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Behavioural single-port dmem: combinational read, write on the rising edge.
  logic [N-1:0] dmem_arr [16] = '{default: '0};
  assign bus.mem_rdata = dmem_arr[bus.mem_addr[3:0]];
  always @(posedge clk) begin
    if (bus.mem_we) dmem_arr[bus.mem_addr[3:0]] <= bus.mem_wdata;
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_ack0   = 0;
  int n_ack1   = 0;
  int n_we     = 0;

  always @(negedge clk) begin
    if (bus.ack0)   n_ack0++;
    if (bus.ack1)   n_ack1++;
    if (bus.mem_we) n_we++;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  // One complete transaction on a single port, starting and ending in IDLE.
  task automatic do_txn(input int p, input logic we, input logic [N-1:0] addr,
                        input logic [N-1:0] wdata);
    logic got;
    got = 1'b0;
    if (p == 0) begin
      bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; bus.req0 = 1'b1;
    end else begin
      bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; bus.req1 = 1'b1;
    end
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if ((p == 0 && bus.ack0) || (p == 1 && bus.ack1)) got = 1'b1;
    end
    chk1("txn_ack_within_budget", got, 1'b1);
    if (p == 0) bus.req0 = 1'b0;
    else        bus.req1 = 1'b0;
    tick();
  endtask

  typedef struct {
    logic         rst_n;
    logic         req0, we0;
    logic [N-1:0] addr0, wdata0;
    logic         req1, we1;
    logic [N-1:0] addr1, wdata1;
    logic         e_ack0, e_ack1, e_busy, e_owner, e_mem_we;
    logic [N-1:0] e_rdata0, e_rdata1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r, input logic q0, input logic w0, input logic [N-1:0] a0, input logic [N-1:0] d0,
    input logic q1, input logic w1, input logic [N-1:0] a1, input logic [N-1:0] d1,
    input logic k0, input logic k1, input logic b, input logic o, input logic mw,
    input logic [N-1:0] r0, input logic [N-1:0] r1);
    vec_t v;
    v.rst_n = r; v.req0 = q0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
    v.req1 = q1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1;
    v.e_ack0 = k0; v.e_ack1 = k1; v.e_busy = b; v.e_owner = o; v.e_mem_we = mw;
    v.e_rdata0 = r0; v.e_rdata1 = r1;
    return v;
  endfunction

  // Transaction-level reference model state.
  int           m_slot;
  logic         m_last, m_owner, m_we;
  logic [N-1:0] m_addr, m_wdata;
  logic [N-1:0] m_rd [2];
  logic [N-1:0] ref_mem [16];
  logic [N-1:0] exp_q [$];

  logic         pend [2];
  logic         c_we [2];
  logic [N-1:0] c_addr [2];
  logic [N-1:0] c_wdata [2];
  logic         d_req [2];
  logic         d_we [2];
  logic [N-1:0] d_addr [2];
  logic [N-1:0] d_wdata [2];

  logic [N-1:0] s6_exp [4];
  int           a0_base, a1_base, we_base;
  logic [N-1:0] got_rd;

  initial begin
    drive_idle();
    rst_n = 1'b0;

    // Write then read on port 0, then the first tie after a reset.
    vecs.push_back(mk(0, 0,0,0,0,                 0,0,0,0, 0,0,0,0,0, 0,0));
    vecs.push_back(mk(1, 1,1,0,32'hFFFF_FFFF,     0,0,0,0, 0,0,1,0,1, 0,0));
    vecs.push_back(mk(1, 0,0,0,0,                 0,0,0,0, 1,0,1,0,0, 0,0));
    vecs.push_back(mk(1, 1,0,0,0,                 0,0,0,0, 0,0,0,0,0, 0,0));
    vecs.push_back(mk(1, 1,0,0,0,                 0,0,0,0, 0,0,1,0,0, 0,0));
    vecs.push_back(mk(1, 0,0,0,0,                 0,0,0,0, 1,0,1,0,0, 32'hFFFF_FFFF,0));
    vecs.push_back(mk(1, 0,0,0,0,                 0,0,0,0, 0,0,0,0,0, 32'hFFFF_FFFF,0));
    vecs.push_back(mk(0, 0,0,0,0,                 0,0,0,0, 0,0,0,0,0, 0,0));
    vecs.push_back(mk(1, 1,1,1,32'h0000_FFFF,     1,0,1,0, 0,0,1,0,1, 0,0));
    vecs.push_back(mk(1, 0,0,0,0,                 1,0,1,0, 1,0,1,0,0, 0,0));
    vecs.push_back(mk(1, 0,0,0,0,                 1,0,1,0, 0,0,0,0,0, 0,0));
    vecs.push_back(mk(1, 0,0,0,0,                 1,0,1,0, 0,0,1,1,0, 0,0));
    vecs.push_back(mk(1, 0,0,0,0,                 0,0,0,0, 0,1,1,1,0, 0,32'h0000_FFFF));
    vecs.push_back(mk(1, 0,0,0,0,                 0,0,0,0, 0,0,0,1,0, 0,32'h0000_FFFF));

    we_base = n_we;
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n;
      bus.req0 = vecs[i].req0; bus.we0 = vecs[i].we0;
      bus.addr0 = vecs[i].addr0; bus.wdata0 = vecs[i].wdata0;
      bus.req1 = vecs[i].req1; bus.we1 = vecs[i].we1;
      bus.addr1 = vecs[i].addr1; bus.wdata1 = vecs[i].wdata1;
      tick();
      chk1($sformatf("vec%0d_ack0", i), bus.ack0, vecs[i].e_ack0);
      chk1($sformatf("vec%0d_ack1", i), bus.ack1, vecs[i].e_ack1);
      chk1($sformatf("vec%0d_busy", i), bus.busy, vecs[i].e_busy);
      chk1($sformatf("vec%0d_owner", i), bus.owner, vecs[i].e_owner);
      chk1($sformatf("vec%0d_mem_we", i), bus.mem_we, vecs[i].e_mem_we);
      chkw($sformatf("vec%0d_rdata0", i), bus.rdata0, vecs[i].e_rdata0);
      chkw($sformatf("vec%0d_rdata1", i), bus.rdata1, vecs[i].e_rdata1);
      if (i == 0) begin
        chkw("reset_mem_addr", bus.mem_addr, '0);
        chkw("reset_mem_wdata", bus.mem_wdata, '0);
      end
    end
    chkw("vec_two_write_cycles", N'(n_we - we_base), N'(2));

    // Fairness: both ports held high for six transactions.
    drive_idle();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    a0_base = n_ack0; a1_base = n_ack1;
    bus.req0 = 1'b1; bus.addr0 = 32'd5;
    bus.req1 = 1'b1; bus.addr1 = 32'd6;
    for (int k = 0; k < 18; k++) begin
      tick();
      if (k % 3 == 0) begin
        chk1($sformatf("fair_owner_%0d", k / 3), bus.owner, 1'((k / 3) % 2));
        chk1("fair_busy_access", bus.busy, 1'b1);
      end else if (k % 3 == 1) begin
        chk1("fair_ack0", bus.ack0, (k / 3) % 2 == 0);
        chk1("fair_ack1", bus.ack1, (k / 3) % 2 == 1);
      end else begin
        chk1("fair_busy_idle", bus.busy, 1'b0);
      end
    end
    drive_idle();
    chkw("fair_ack0_count", N'(n_ack0 - a0_base), N'(3));
    chkw("fair_ack1_count", N'(n_ack1 - a1_base), N'(3));

    // Abandoned request: port 1 drops req in its ACCESS cycle.
    do_txn(0, 1'b1, 32'd2, 32'h1234_5678);
    a1_base = n_ack1;
    bus.we1 = 1'b1; bus.addr1 = 32'd2; bus.wdata1 = 32'h0; bus.req1 = 1'b1;
    tick();
    chk1("abandon_mem_we", bus.mem_we, 1'b1);
    chk1("abandon_owner", bus.owner, 1'b1);
    bus.req1 = 1'b0; bus.wdata1 = 32'hFFFF_0000; bus.addr1 = 32'd9;
    tick();
    chk1("abandon_ack1", bus.ack1, 1'b1);
    for (int k = 0; k < 6; k++) tick();
    chk1("abandon_idle", bus.busy, 1'b0);
    chkw("abandon_single_ack", N'(n_ack1 - a1_base), N'(1));
    chkw("abandon_write_landed", dmem_arr[2], 32'h0);
    chkw("abandon_nothing_at_9", dmem_arr[9], 32'h0);
    do_txn(0, 1'b0, 32'd2, 32'h0);
    chkw("abandon_readback", bus.rdata0, 32'h0);

    // Reset landing in the ACCESS cycle of a write.
    do_txn(1, 1'b1, 32'd3, 32'hA5A5_A5A5);
    a0_base = n_ack0; a1_base = n_ack1;
    bus.we0 = 1'b1; bus.addr0 = 32'd3; bus.wdata0 = 32'hDEAD_BEEF; bus.req0 = 1'b1;
    tick();
    chk1("rst_mid_mem_we_before", bus.mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rst_mid_mem_we_gated", bus.mem_we, 1'b0);
    bus.req0 = 1'b0;
    tick();
    chk1("rst_mid_busy", bus.busy, 1'b0);
    chk1("rst_mid_owner", bus.owner, 1'b0);
    chk1("rst_mid_ack0", bus.ack0, 1'b0);
    chk1("rst_mid_ack1", bus.ack1, 1'b0);
    chkw("rst_mid_mem_addr", bus.mem_addr, '0);
    chkw("rst_mid_mem_wdata", bus.mem_wdata, '0);
    chkw("rst_mid_rdata0", bus.rdata0, '0);
    chkw("rst_mid_rdata1", bus.rdata1, '0);
    rst_n = 1'b1;
    tick();
    chkw("rst_mid_dmem3_kept", dmem_arr[3], 32'hA5A5_A5A5);
    chkw("rst_mid_no_ack", N'((n_ack0 - a0_base) + (n_ack1 - a1_base)), N'(0));
    bus.we0 = 1'b0; bus.addr0 = 32'd0; bus.req0 = 1'b1;
    bus.we1 = 1'b0; bus.addr1 = 32'd1; bus.req1 = 1'b1;
    tick();
    chk1("rst_mid_next_tie_port0", bus.owner, 1'b0);
    drive_idle();
    tick();
    chk1("rst_mid_tie_ack0", bus.ack0, 1'b1);
    chkw("rst_mid_tie_rdata0", bus.rdata0, 32'hFFFF_FFFF);
    tick();

    // Port 1 streaming four reads with req held.
    s6_exp[0] = 32'hFFFF_FFFF; s6_exp[1] = 32'h0000_FFFF;
    s6_exp[2] = 32'h0000_0000; s6_exp[3] = 32'hA5A5_A5A5;
    a0_base = n_ack0; a1_base = n_ack1;
    bus.we1 = 1'b0; bus.addr1 = 32'd0; bus.req1 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk1($sformatf("stream_ack1_k%0d", k), bus.ack1, k % 3 == 1);
      chk1("stream_ack0", bus.ack0, 1'b0);
      if (k % 3 == 1) begin
        chkw($sformatf("stream_rdata1_%0d", k / 3), bus.rdata1, s6_exp[k / 3]);
        bus.addr1 = N'(k / 3 + 1);
        if (k / 3 == 3) bus.req1 = 1'b0;
      end
    end
    for (int k = 0; k < 4; k++) tick();
    chkw("stream_ack1_count", N'(n_ack1 - a1_base), N'(4));
    chkw("stream_ack0_count", N'(n_ack0 - a0_base), N'(0));
    chkw("stream_rdata0_held", bus.rdata0, 32'hFFFF_FFFF);

    // Random traffic against the transaction-level model.
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = dmem_arr[i];
    m_slot = 0; m_last = 1'b1; m_owner = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_rd[0] = '0; m_rd[1] = '0;
    exp_q.delete();
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; c_we[p] = 1'b0; c_addr[p] = '0; c_wdata[p] = '0;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      chk1("rnd_busy", bus.busy, m_slot != 0);
      chk1("rnd_owner", bus.owner, m_owner);
      chk1("rnd_ack0", bus.ack0, m_slot == 1 && !m_owner);
      chk1("rnd_ack1", bus.ack1, m_slot == 1 && m_owner);
      chk1("rnd_mem_we", bus.mem_we, m_slot == 2 && m_we);
      chkw("rnd_mem_addr", bus.mem_addr, m_addr);
      chkw("rnd_mem_wdata", bus.mem_wdata, m_wdata);
      chkw("rnd_rdata0", bus.rdata0, m_rd[0]);
      chkw("rnd_rdata1", bus.rdata1, m_rd[1]);
      if (m_slot == 1 && !m_we) begin
        if (exp_q.size() == 0) begin
          chk1("rnd_scoreboard_empty", 1'b1, 1'b0);
        end else begin
          got_rd = m_owner ? bus.rdata1 : bus.rdata0;
          chkw("rnd_read_data", got_rd, exp_q.pop_front());
        end
      end

      for (int p = 0; p < 2; p++) begin
        if (m_slot == 1 && m_owner == 1'(p)) pend[p] = 1'b0;
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p]    = 1'b1;
          c_we[p]    = 1'($urandom_range(0, 1));
          c_addr[p]  = N'($urandom_range(0, 15));
          c_wdata[p] = $urandom;
        end
        if (m_slot == 2 && m_owner == 1'(p)) begin
          d_req[p]   = 1'($urandom_range(0, 1));
          d_we[p]    = 1'($urandom_range(0, 1));
          d_addr[p]  = N'($urandom_range(0, 15));
          d_wdata[p] = $urandom;
        end else begin
          d_req[p]   = pend[p];
          d_we[p]    = c_we[p];
          d_addr[p]  = c_addr[p];
          d_wdata[p] = c_wdata[p];
        end
      end
      bus.req0 = d_req[0]; bus.we0 = d_we[0]; bus.addr0 = d_addr[0]; bus.wdata0 = d_wdata[0];
      bus.req1 = d_req[1]; bus.we1 = d_we[1]; bus.addr1 = d_addr[1]; bus.wdata1 = d_wdata[1];

      if (m_slot == 0) begin
        if (d_req[0] || d_req[1]) begin
          m_owner = (d_req[0] && d_req[1]) ? !m_last : d_req[1];
          m_we    = d_we[m_owner];
          m_addr  = d_addr[m_owner];
          m_wdata = d_wdata[m_owner];
          m_slot  = 2;
        end
      end else if (m_slot == 2) begin
        if (m_we) begin
          ref_mem[m_addr[3:0]] = m_wdata;
        end else begin
          m_rd[m_owner] = ref_mem[m_addr[3:0]];
          exp_q.push_back(m_rd[m_owner]);
        end
        m_slot = 1;
      end else begin
        m_last = m_owner;
        m_slot = 0;
      end
      @(negedge clk);
    end
    drive_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
